// File: rtl/mdu_pkg.sv
// mdu_pkg: op encoding, FSM state type and op-class helpers for the multiply/divide unit
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Codes 8..15 are unassigned and must never be accepted
    function automatic logic is_valid(input logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational HI/LO result for one mdu op (product, accumulate, divide with corner cases)
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic               sgn;
    logic [2*WIDTH-1:0] ax, bx, prod, acc, mres;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   ua, ub, uq, ur, q, r;

    // One shared multiplier and one shared unsigned divider; signed ops fold signs around them.
    // A most-negative/-1 divide falls out naturally: |a| = 2^(W-1), negated back to most-negative, rem 0.
    always_comb begin
        sgn   = is_signed(op_i);
        ax    = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
        bx    = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
        prod  = ax * bx;
        acc   = {hi_i, lo_i};
        mres  = (op_i == OP_MADD || op_i == OP_MADDU) ? acc + prod :
                (op_i == OP_MSUB || op_i == OP_MSUBU) ? acc - prod : prod;
        neg_a = sgn & a_i[WIDTH-1];
        neg_b = sgn & b_i[WIDTH-1];
        ua    = neg_a ? -a_i : a_i;
        ub    = neg_b ? -b_i : b_i;
        uq    = (ub == '0) ? '0 : ua / ub;
        ur    = (ub == '0) ? '0 : ua % ub;
        q     = (neg_a ^ neg_b) ? -uq : uq;
        r     = neg_a ? -ur : ur;
        hi_o  = !is_div(op_i) ? mres[2*WIDTH-1:WIDTH] : (b_i == '0) ? a_i : r;
        lo_o  = !is_div(op_i) ? mres[WIDTH-1:0] : (b_i == '0) ? '1 : q;
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: multiply/divide unit with fixed-latency countdown, staged result commit and flush abort
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q, stage_hi_q, stage_lo_q;
    logic [WIDTH-1:0] stage_hi_d, stage_lo_d;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .op_i (op_i),
        .a_i  (src_a_i),
        .b_i  (src_b_i),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (stage_hi_d),
        .lo_o (stage_lo_d)
    );

    // FSM: result is computed at accept, held in staging, and only reaches HI/LO when the countdown expires
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            stage_hi_q <= '0;
            stage_lo_q <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (cnt_q == CW'(1)) begin
                hi_q    <= stage_hi_q;
                lo_q    <= stage_lo_q;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                if (is_valid(op_i)) begin
                    stage_hi_q <= stage_hi_d;
                    stage_lo_q <= stage_lo_d;
                    cnt_q      <= is_div(op_i) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                    busy_q     <= 1'b1;
                    state_q    <= ST_RUN;
                end
            end else begin
                if (hi_we_i) hi_q <= src_a_i;
                if (lo_we_i) lo_q <= src_a_i;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors against a transaction-level HI/LO model plus literal spot checks
module tb_mdu_iter;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 0, rst = 0;
    logic        start = 0, hi_we = 0, lo_we = 0, flush = 0;
    logic [3:0]  op = 0;
    logic [31:0] src_a = 0, src_b = 0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int total = 0, bad = 0, done_cnt = 0;
    bit chk_on = 0;

    mdu_iter #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .start_i (start),
        .op_i    (op),
        .src_a_i (src_a),
        .src_b_i (src_b),
        .hi_we_i (hi_we),
        .lo_we_i (lo_we),
        .flush_i (flush),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Full-width arithmetic straight from the op definitions
    function automatic logic [63:0] model_res(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] acc);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        longint q, r;
        case (o)
            4'd0: return 64'(sa * sb);
            4'd1: return ua * ub;
            4'd2: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd3: return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            4'd4: return acc + 64'(sa * sb);
            4'd5: return acc + ua * ub;
            4'd6: return acc - 64'(sa * sb);
            default: return acc - ua * ub;
        endcase
    endfunction

    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_res = 0;
    bit          m_busy = 0, m_done = 0;
    int          cyc = 0, m_at = 0;

    // Model: an accepted op commits exactly LAT edges after its accept edge unless flushed first
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi <= 0; m_lo <= 0; m_busy <= 0; m_done <= 0; cyc <= 0; m_at <= 0; m_res <= 0;
        end else begin
            cyc    <= cyc + 1;
            m_done <= 0;
            if (flush) m_busy <= 0;
            else if (m_busy) begin
                if (cyc == m_at) begin
                    m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1; m_busy <= 0;
                end
            end else if (start) begin
                if (op < 8) begin
                    m_res  <= model_res(op, src_a, src_b, {m_hi, m_lo});
                    m_busy <= 1;
                    m_at   <= cyc + ((op == 2 || op == 3) ? DIV_LAT : MUL_LAT);
                end
            end else begin
                if (hi_we) m_hi <= src_a;
                if (lo_we) m_lo <= src_a;
            end
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #1;
        if (done_o) done_cnt++;
        if (chk_on) chk("cyc", {busy_o, done_o, hi_o, lo_o}, {m_busy, m_done, m_hi, m_lo});
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); start = 1; op = o; src_a = a; src_b = b;
        @(negedge clk); start = 0;
    endtask

    task automatic wr(input logic h, input logic l, input logic [31:0] a);
        @(negedge clk); hi_we = h; lo_we = l; src_a = a;
        @(negedge clk); hi_we = 0; lo_we = 0;
    endtask

    task automatic run(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] eh, input logic [31:0] el);
        int n = 0;
        issue(o, a, b);
        while (busy_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_lat"}, 66'(n), 66'(lat));
        chk({nm, "_done"}, 66'(done_o), 66'(1));
        chk({nm, "_hi"}, 66'(hi_o), 66'(eh));
        chk({nm, "_lo"}, 66'(lo_o), 66'(el));
    endtask

    initial begin
        int d0;
        #1 rst = 1;
        repeat (2) @(negedge clk);
        chk("rst_out", {busy_o, done_o, hi_o, lo_o}, 66'(0));
        rst = 0;
        chk_on = 1;

        wr(0, 1, 32'd5);
        chk("mtlo", 66'(lo_o), 66'(5));
        issue(4'd0, 32'd3, 32'd3);
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        chk("rst_mid", {busy_o, hi_o, lo_o}, 66'(0));
        @(negedge clk);
        rst = 0;
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("rst_nodone", 66'(done_cnt), 66'(d0));

        run("mult",  4'd0, 32'hFFFFFFFF, 32'd2, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("multu", 4'd1, 32'hFFFFFFFF, 32'd2, MUL_LAT, 32'h00000001, 32'hFFFFFFFE);
        run("div",   4'd2, 32'hFFFFFFF9, 32'd2, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divz",  4'd3, 32'h00001234, 32'd0, DIV_LAT, 32'h00001234, 32'hFFFFFFFF);
        run("divov", 4'd2, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0, 32'h80000000);
        run("divu",  4'd3, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);

        wr(1, 0, 32'd0);
        wr(0, 1, 32'd10);
        run("madd",  4'd4, 32'd3, 32'd4, MUL_LAT, 32'h0, 32'd22);
        run("msub",  4'd6, 32'd5, 32'd5, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_busy", 66'(busy_o), 66'(0));
        chk("flush_hilo", {2'b0, hi_o, lo_o}, {2'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("flush_nodone", 66'(done_cnt), 66'(d0));

        @(negedge clk); start = 1; flush = 1; op = 4'd0; src_a = 32'd9; src_b = 32'd9; hi_we = 1;
        @(negedge clk); start = 0; flush = 0; hi_we = 0;
        chk("stflush_busy", 66'(busy_o), 66'(0));
        chk("stflush_hi", 66'(hi_o), 66'(32'hFFFFFFFF));

        @(negedge clk); start = 1; op = 4'd8; src_a = 32'd3; src_b = 32'd3;
        @(negedge clk); start = 0;
        chk("badop_busy", 66'(busy_o), 66'(0));

        @(negedge clk); hi_we = 1; start = 1; op = 4'd1; src_a = 32'hAAAA; src_b = 32'd2;
        @(negedge clk); hi_we = 0; start = 0;
        chk("wrst_busy", 66'(busy_o), 66'(1));
        chk("wrst_hi_kept", 66'(hi_o), 66'(32'hFFFFFFFF));
        repeat (MUL_LAT) @(negedge clk);
        chk("wrst_res", {2'b0, hi_o, lo_o}, {2'b0, 32'h0, 32'h00015554});

        wr(1, 1, 32'h5A5A5A5A);
        chk("both_we", {2'b0, hi_o, lo_o}, {2'b0, 32'h5A5A5A5A, 32'h5A5A5A5A});

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
